// File: rtl/width_conv_pkg.sv
// Shared sizing helpers for the width converter and its benches.
package width_conv_pkg;

    // Ceiling log2, never less than 1 so derived vectors always have a bit.
    function automatic int clog2_up(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Buffer must hold one partial output word plus one whole input beat.
    function automatic int buf_width(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

    // Counter covers 0..buf_width inclusive.
    function automatic int cnt_width(input int in_w, input int out_w);
        return clog2_up(in_w + out_w);
    endfunction

    // out_bits covers 0..out_w inclusive.
    function automatic int bits_width(input int out_w);
        return clog2_up(out_w + 1);
    endfunction

    localparam int DEF_IN_W   = 8;
    localparam int DEF_OUT_W  = 12;
    localparam int DEF_BUF_W  = buf_width(DEF_IN_W, DEF_OUT_W);
    localparam int DEF_BITS_W = bits_width(DEF_OUT_W);

endpackage

// File: rtl/width_conv.sv
// MSB-first stream repacker: IN_W-bit beats in, OUT_W-bit words out,
// valid/ready on both sides, zero-padded partial word on packet end.
module width_conv
    import width_conv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_last,
    output logic [bits_width(OUT_W)-1:0]  out_bits
);

    localparam int BUF_W  = buf_width(IN_W, OUT_W);
    localparam int CNT_W  = cnt_width(IN_W, OUT_W);
    localparam int BITS_W = bits_width(OUT_W);
    localparam int SUM_W  = CNT_W + 1;
    localparam int PAD_W  = BUF_W - IN_W;

    localparam logic [CNT_W-1:0] C_OUT_W   = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] C_IN_W    = CNT_W'(IN_W);
    localparam logic [SUM_W-1:0] C_IN_W_S  = SUM_W'(IN_W);
    localparam logic [SUM_W-1:0] C_BUF_W_S = SUM_W'(BUF_W);

    generate
        if (IN_W < 1) begin : g_bad_in_w
            $error("width_conv: IN_W must be >= 1");
        end
        if (OUT_W < 1) begin : g_bad_out_w
            $error("width_conv: OUT_W must be >= 1");
        end
    endgenerate

    // Valid bits sit MSB-aligned in r_buf; everything below r_cnt is zero.
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_pend;

    logic             w_full;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_out_fire;
    logic             w_in_fire;
    logic             w_room;
    logic [CNT_W-1:0] w_take;
    logic [CNT_W-1:0] w_cnt_o;
    logic [BUF_W-1:0] w_buf_o;
    logic [BUF_W-1:0] w_in_aligned;

    // Drain side: word presentation and the buffer state after any out_fire.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        w_full      = (r_cnt >= C_OUT_W);
        w_take      = w_full ? C_OUT_W : r_cnt;
        w_out_valid = !rst && (w_full || (r_last_pend && (r_cnt != '0)));
        w_out_last  = !rst && r_last_pend && (r_cnt <= C_OUT_W);
        w_out_fire  = w_out_valid && out_ready;
        w_cnt_o     = w_out_fire ? (r_cnt - w_take) : r_cnt;
        w_buf_o     = w_out_fire ? (r_buf << OUT_W) : r_buf;
    end

    // Fill side: room is judged after this cycle's drain, so a draining word
    // frees space for a beat in the same cycle (out_ready -> in_ready path).
    always_comb begin
        w_room       = ((SUM_W'(w_cnt_o) + C_IN_W_S) <= C_BUF_W_S);
        in_ready     = !rst && !r_last_pend && w_room;
        w_in_fire    = in_valid && in_ready;
        w_in_aligned = (BUF_W'(in_data) << PAD_W) >> w_cnt_o;
    end

    // Output word view; forced to zero while reset is held.
    always_comb begin
        out_valid = w_out_valid;
        out_last  = w_out_last;
        out_data  = rst ? '0 : r_buf[BUF_W-1 -: OUT_W];
        out_bits  = rst ? '0 : BITS_W'(w_take);
    end

    // Buffer, counter and packet-end flag: drain first, then append.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_last_pend <= 1'b0;
        end else begin
            r_buf <= w_in_fire ? (w_buf_o | w_in_aligned) : w_buf_o;
            r_cnt <= w_in_fire ? (w_cnt_o + C_IN_W) : w_cnt_o;
            if (w_in_fire && in_last) begin
                r_last_pend <= 1'b1;
            end else if (w_out_fire && w_out_last) begin
                r_last_pend <= 1'b0;
            end
        end
    end

endmodule
